// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Time-multiplexed hex driver for an N-digit common-anode 7-segment
//            display. One digit is scanned per refresh slot, over shared
//            active-low segment lines and per-digit active-low anodes.
//            The displayed value is double-buffered and is swapped only at a
//            frame boundary, so a scan never shows a mix of old and new digits.
//            The driver also provides leading-zero suppression, a per-digit
//            enable, decimal points and anti-ghost blanking.
// Ports    : clk        - system clock
//            rst_n      - asynchronous active-low reset (released synchronously)
//            load       - 1-cycle strobe; captures value/dp_in into the pending buffer
//            value      - hex nibbles, [3:0] = digit 0 (rightmost)
//            dp_in      - decimal point per digit, 1 = lit
//            digit_en   - live per-digit enable, 0 = dark
//            lzs        - live leading-zero suppression enable
//            seg        - {dp,g,f,e,d,c,b,a}, active-low, registered
//            an         - digit anodes, active-low, registered
//            frame_done - 1-cycle pulse after the last digit slot ends
// Params   : NUM_DIGITS  1..8
//            REFRESH_DIV >= 2         clk cycles per digit slot
//            BLANK_CYC   0..REFRESH_DIV-1  dark cycles at the start of each slot
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lzs,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  // --------------------------------------------------------------------------
  // Widths and constants
  // --------------------------------------------------------------------------
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] C_CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] C_IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] C_BLANK    = CW'(BLANK_CYC);

  // --------------------------------------------------------------------------
  // Hex to segment decode, returns {g,f,e,d,c,b,a} active-low
  // --------------------------------------------------------------------------
  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [VW-1:0]         r_pend_val;
  logic [NUM_DIGITS-1:0] r_pend_dp;
  logic                  r_pend_valid;
  logic [VW-1:0]         r_act_val;
  logic [NUM_DIGITS-1:0] r_act_dp;

  logic                  w_slot_end;
  logic                  w_frame_end;

  assign w_slot_end  = (r_cnt == C_CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == C_IDX_LAST);

  // --------------------------------------------------------------------------
  // Slot prescaler and digit index. With a single digit the index stays at 0
  // and every slot end is also a frame end.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_frame_end;
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == C_IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Double buffer. A load on the frame-end cycle goes straight to the active
  // buffer so it is shown from the very next frame without a one-frame delay.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_act_val    <= '0;
      r_act_dp     <= '0;
    end else begin
      if (load) begin
        r_pend_val <= value;
        r_pend_dp  <= dp_in;
      end
      if (w_frame_end) begin
        r_pend_valid <= 1'b0;
        if (load) begin
          r_act_val <= value;
          r_act_dp  <= dp_in;
        end else if (r_pend_valid) begin
          r_act_val <= r_pend_val;
          r_act_dp  <= r_pend_dp;
        end
      end else if (load) begin
        r_pend_valid <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Leading-zero suppression: digit i (i>0) is suppressed when it and every
  // more significant nibble are zero. Digit 0 always shows.
  // --------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] w_nib_zero;
  logic [NUM_DIGITS-1:0] w_supp;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzs
    assign w_nib_zero[gi] = (r_act_val[4*gi +: 4] == 4'h0);
    if (gi == 0) begin : g_d0
      assign w_supp[gi] = 1'b0;
    end else begin : g_dn
      assign w_supp[gi] = lzs && (&w_nib_zero[NUM_DIGITS-1:gi]);
    end
  end

  // --------------------------------------------------------------------------
  // Select the digit currently being scanned
  // --------------------------------------------------------------------------
  logic [3:0] w_cur_nib;
  logic       w_cur_dp;
  logic       w_cur_en;
  logic       w_cur_supp;

  always_comb begin
    w_cur_nib  = 4'h0;
    w_cur_dp   = 1'b0;
    w_cur_en   = 1'b0;
    w_cur_supp = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_cur_nib  = r_act_val[4*i +: 4];
        w_cur_dp   = r_act_dp[i];
        w_cur_en   = digit_en[i];
        w_cur_supp = w_supp[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Anti-ghost blanking at the start of every slot. A zero-length interval
  // is handled separately so the compare against zero never appears.
  // --------------------------------------------------------------------------
  logic w_blank;

  if (BLANK_CYC == 0) begin : g_no_blank
    assign w_blank = 1'b0;
  end else begin : g_blank
    assign w_blank = (r_cnt < C_BLANK);
  end

  // A suppressed digit is still driven when its decimal point is lit. A
  // disabled digit keeps its anode off but still consumes its slot, so every
  // enabled digit sees the same duty cycle.
  logic                  w_lit;
  logic [7:0]            w_seg_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;

  assign w_lit = !w_blank && w_cur_en && !(w_cur_supp && !w_cur_dp);

  always_comb begin
    if (w_blank) begin
      w_seg_nxt = 8'hFF;
    end else begin
      w_seg_nxt = {~w_cur_dp, (w_cur_supp ? 7'h7F : seg7_decode(w_cur_nib))};
    end
  end

  always_comb begin
    w_an_nxt = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_lit && (r_idx == IW'(i))) begin
        w_an_nxt[i] = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered display outputs: they lag the scan state by one cycle and go
  // dark immediately on reset assertion.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 8'hFF;
      an  <= '1;
    end else begin
      seg <= w_seg_nxt;
      an  <= w_an_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Directed self-checking bench for seg7_scan_driver with
//            NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1 (16-cycle frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        lzs;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  seg7_scan_driver #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLANK_CYC   (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .lzs        (lzs),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Checks one full frame. Called at a negedge where the scan state is at
  // phase 0 of a frame; returns at the same position of the next frame.
  // exp_seg = {d3,d2,d1,d0} segment bytes, lit = digits expected to light.
  // ld_ph >= 0 pulses load while the scan state is at that phase.
  task automatic check_frame(input string tag, input logic [31:0] exp_seg,
                             input logic [3:0] lit, input int ld_ph,
                             input logic [15:0] ld_val, input logic [3:0] ld_dp);
    for (int p = 0; p < 16; p++) begin
      int         d;
      int         c;
      logic [3:0] e_an;
      if (p == ld_ph) begin
        value = ld_val;
        dp_in = ld_dp;
        load  = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      load = 1'b0;
      d = p / 4;
      c = p % 4;
      chk_eq($sformatf("%s.p%0d.frame_done", tag, p), {31'd0, frame_done}, {31'd0, (p == 15)});
      if (c == 0) begin
        chk_eq($sformatf("%s.p%0d.blank_an", tag, p), {28'd0, an}, 32'hF);
        chk_eq($sformatf("%s.p%0d.blank_seg", tag, p), {24'd0, seg}, 32'hFF);
      end else if (lit[d]) begin
        e_an    = 4'hF;
        e_an[d] = 1'b0;
        chk_eq($sformatf("%s.p%0d.an", tag, p), {28'd0, an}, {28'd0, e_an});
        chk_eq($sformatf("%s.p%0d.seg", tag, p), {24'd0, seg}, {24'd0, exp_seg[8*d +: 8]});
      end else begin
        chk_eq($sformatf("%s.p%0d.dark_an", tag, p), {28'd0, an}, 32'hF);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = 16'h0;
    dp_in    = 4'h0;
    digit_en = 4'hF;
    lzs      = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_eq("rst.seg", {24'd0, seg}, 32'hFF);
    chk_eq("rst.an", {28'd0, an}, 32'hF);
    chk_eq("rst.frame_done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;

    // Idle scan of an all-zero value
    check_frame("f1_idle", 32'hC0C0C0C0, 4'hF, -1, 16'h0, 4'h0);
    // Mid-frame load: current frame keeps old digits
    check_frame("f2_old", 32'hC0C0C0C0, 4'hF, 5, 16'h1A3F, 4'b0100);
    check_frame("f3_new", 32'hF908B08E, 4'hF, -1, 16'h0, 4'h0);
    // Value holds; load 0050 with suppression enabled for the next frame
    lzs = 1'b1;
    check_frame("f4_hold", 32'hF908B08E, 4'hF, 3, 16'h0050, 4'h0);
    check_frame("f5_lzs", 32'hFFFF92C0, 4'b0011, 3, 16'h0000, 4'h0);
    check_frame("f6_lzs0", 32'hFFFFFFC0, 4'b0001, 3, 16'h0000, 4'b1000);
    // Suppressed digit with its decimal point still lights the dp only
    check_frame("f7_lzsdp", 32'h7FFFFFC0, 4'b1001, -1, 16'h0, 4'h0);
    // Load on the frame-end cycle bypasses straight to the display
    lzs = 1'b0;
    check_frame("f8_pre", 32'h40C0C0C0, 4'hF, 15, 16'h2222, 4'h0);
    check_frame("f9_byp", 32'hA4A4A4A4, 4'hF, 0, 16'h3333, 4'h0);
    check_frame("f10_wait", 32'hB0B0B0B0, 4'hF, -1, 16'h0, 4'h0);
    // Disabled digit 2 stays dark for its whole slot
    digit_en = 4'b1011;
    check_frame("f11_en", 32'hB0B0B0B0, 4'b1011, -1, 16'h0, 4'h0);

    // Reset asserted in the middle of digit 2's slot
    digit_en = 4'hF;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk_eq("mid.an", {28'd0, an}, 32'hB);
    chk_eq("mid.seg", {24'd0, seg}, 32'hB0);
    rst_n = 1'b0;
    #1;
    chk_eq("arst.seg", {24'd0, seg}, 32'hFF);
    chk_eq("arst.an", {28'd0, an}, 32'hF);
    chk_eq("arst.frame_done", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_frame("f12_rst", 32'hC0C0C0C0, 4'hF, -1, 16'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
